// File: rtl/mem_ctrl.sv
// Load/store controller between the CPU LSU and a word-wide block RAM; byte stores use read-modify-write.
// Optional misalignment fault for word accesses is enabled by defining MEMCTRL_ALIGN_CHECK_EN.
module mem_ctrl #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic              wr_i,
  input  logic              byte_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [15:0]       wdata_i,
  output logic [15:0]       rdata_o,
  output logic              ack_o,
  output logic              busy_o,
  output logic              fault_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [15:0]       ram_din_o,
  output logic [1:0]        ram_be_o,
  output logic              ram_we_o,
  input  logic [15:0]       ram_dout_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic              byte_q, byte_d;
  logic              lane_q, lane_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       din_q, din_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              misalign;
  logic [7:0]        rd_byte;
  logic [15:0]       merged;

`ifdef MEMCTRL_ALIGN_CHECK_EN
  assign misalign = !byte_i && addr_i[0];
`else
  assign misalign = 1'b0;
`endif

  // Big-endian lanes: addr[0]=0 is the high byte. din_q[7:0] still holds the store byte.
  assign rd_byte = lane_q ? ram_dout_i[7:0] : ram_dout_i[15:8];
  assign merged  = lane_q ? {ram_dout_i[15:8], din_q[7:0]} : {din_q[7:0], ram_dout_i[7:0]};

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    byte_d  = byte_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          wr_d    = wr_i;
          byte_d  = byte_i;
          lane_d  = addr_i[0];
          addr_d  = {1'b0, addr_i[ADDR_W-1:1]};
          din_d   = wdata_i;
          cnt_d   = 2'd0;
          fault_d = misalign;
          if (misalign)            state_d = DONE;
          else if (wr_i && !byte_i) state_d = WRITE;
          else                     state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 2'd0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      CAPTURE: begin
        if (wr_q) begin
          din_d   = merged;
          state_d = WRITE;
        end else begin
          rdata_d = byte_q ? {8'h00, rd_byte} : ram_dout_i;
          state_d = DONE;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      lane_q  <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      byte_q  <= byte_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rdata_o    = rdata_q;
  assign ack_o      = (state_q == DONE);
  assign busy_o     = (state_q != IDLE);
  assign fault_o    = fault_q;
  assign ram_addr_o = addr_q;
  assign ram_din_o  = din_q;
  assign ram_be_o   = 2'b11;
  assign ram_we_o   = (state_q == WRITE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural registered-read RAM.
module tb_mem_ctrl;
  localparam int ADDR_W = 16;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              reset, req, wr, byt;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata, rdata, ram_din, ram_dout;
  logic              ack, busy, fault, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .wr_i(wr), .byte_i(byt),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack), .busy_o(busy),
    .fault_o(fault), .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_be_o(ram_be),
    .ram_we_o(ram_we), .ram_dout_i(ram_dout)
  );

  logic [15:0] mem  [256];
  logic [15:0] pipe [RD_LAT];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:0]] <= ram_din;
    pipe[0] <= mem[ram_addr[7:0]];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_dout = pipe[RD_LAT-1];

  // Issues one request and observes it until ack (bounded to 20 cycles); lat stays -1 on timeout.
  task automatic do_op(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d,
                       output int lat, output int we_cnt, output logic [15:0] we_din,
                       output logic [15:0] we_addr, output logic [15:0] ack_addr,
                       output logic flt, output int be_bad);
    lat = -1; we_cnt = 0; we_din = '0; we_addr = '0; ack_addr = '0; flt = 1'b0; be_bad = 0;
    @(negedge clk);
    req = 1'b1; wr = w; byt = b; addr = a; wdata = d;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req = 1'b0;
      if (ram_be !== 2'b11) be_bad++;
      if (ram_we === 1'b1) begin
        we_cnt++;
        we_din  = ram_din;
        we_addr = ram_addr;
      end
      if (ack === 1'b1) begin
        lat      = c;
        flt      = fault;
        ack_addr = ram_addr;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; wr = 1'b0; byt = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({ack, busy, fault, ram_we} !== 4'b0000) begin errors++;
      $display("FAIL rst_ctrl: ack/busy/fault/we=%b expected 0000", {ack, busy, fault, ram_we}); end
    checks++; if (rdata !== 16'h0000) begin errors++;
      $display("FAIL rst_rdata: got %h expected 0000", rdata); end
    checks++; if ({ram_addr, ram_din} !== 32'h0) begin errors++;
      $display("FAIL rst_ram: addr %h din %h expected 0", ram_addr, ram_din); end
    checks++; if (ram_be !== 2'b11) begin errors++;
      $display("FAIL rst_be: got %b expected 11", ram_be); end
    reset = 1'b0;
  endtask

  task automatic test_word_store();
    int lat, wc, bb; logic [15:0] wd, wa, aa; logic f;
    do_op(1'b1, 1'b0, 16'h0010, 16'hBEEF, lat, wc, wd, wa, aa, f, bb);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ws_lat: got %0d expected 2", lat); end
    checks++; if (wc !== 1) begin errors++; $display("FAIL ws_we_cnt: got %0d expected 1", wc); end
    checks++; if (wa !== 16'h0008) begin errors++; $display("FAIL ws_addr: got %h expected 0008", wa); end
    checks++; if (wd !== 16'hBEEF) begin errors++; $display("FAIL ws_din: got %h expected beef", wd); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL ws_be: %0d bad cycles expected 0", bb); end
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL ws_fault: got %b expected 0", f); end
  endtask

  task automatic test_word_load();
    int lat, wc, bb; logic [15:0] wd, wa, aa; logic f;
    do_op(1'b0, 1'b0, 16'h0010, 16'h0000, lat, wc, wd, wa, aa, f, bb);
    checks++; if (lat !== 2 + RD_LAT) begin errors++; $display("FAIL wl_lat: got %0d expected %0d", lat, 2 + RD_LAT); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL wl_we_cnt: got %0d expected 0", wc); end
    checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL wl_rdata: got %h expected beef", rdata); end
  endtask

  task automatic test_byte_store_load();
    int lat, wc, bb; logic [15:0] wd, wa, aa; logic f;
    do_op(1'b1, 1'b1, 16'h0011, 16'h0042, lat, wc, wd, wa, aa, f, bb);
    checks++; if (lat !== 3 + RD_LAT) begin errors++; $display("FAIL bs_lat: got %0d expected %0d", lat, 3 + RD_LAT); end
    checks++; if (wc !== 1) begin errors++; $display("FAIL bs_we_cnt: got %0d expected 1", wc); end
    checks++; if (wd !== 16'hBE42) begin errors++; $display("FAIL bs_din: got %h expected be42", wd); end
    checks++; if (wa !== 16'h0008) begin errors++; $display("FAIL bs_addr: got %h expected 0008", wa); end
    do_op(1'b0, 1'b1, 16'h0010, 16'h0000, lat, wc, wd, wa, aa, f, bb);
    checks++; if (rdata !== 16'h00BE) begin errors++; $display("FAIL bl_hi: got %h expected 00be", rdata); end
    checks++; if (lat !== 2 + RD_LAT) begin errors++; $display("FAIL bl_lat: got %0d expected %0d", lat, 2 + RD_LAT); end
    do_op(1'b0, 1'b1, 16'h0011, 16'h0000, lat, wc, wd, wa, aa, f, bb);
    checks++; if (rdata !== 16'h0042) begin errors++; $display("FAIL bl_lo: got %h expected 0042", rdata); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL bl_we_cnt: got %0d expected 0", wc); end
  endtask

  task automatic test_back_to_back();
    int acks, busy_low, bad_w, bad_b;
    logic prev_ack;
    acks = 0; busy_low = 0; bad_w = 0; bad_b = 0; prev_ack = 1'b0;
    @(negedge clk);
    req = 1'b1; wr = 1'b0; byt = 1'b0; addr = 16'h0010;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
      if (busy === 1'b0) busy_low++;
      if (ack === 1'b1 && prev_ack) bad_w++;
      if (busy !== !prev_ack) bad_b++;
      prev_ack = (ack === 1'b1);
    end
    req = 1'b0;
    checks++; if (acks !== 5) begin errors++; $display("FAIL b2b_acks: got %0d expected 5", acks); end
    checks++; if (busy_low !== 5) begin errors++; $display("FAIL b2b_idle: got %0d expected 5", busy_low); end
    checks++; if (bad_w !== 0) begin errors++; $display("FAIL b2b_ack_width: %0d wide pulses expected 0", bad_w); end
    checks++; if (bad_b !== 0) begin errors++; $display("FAIL b2b_busy: %0d bad cycles expected 0", bad_b); end
    checks++; if (rdata !== 16'hBE42) begin errors++; $display("FAIL b2b_rdata: got %h expected be42", rdata); end
  endtask

  task automatic test_reset_mid_op();
    int lat, wc, bb, ev; logic [15:0] wd, wa, aa; logic f;
    do_op(1'b1, 1'b0, 16'h0020, 16'h1234, lat, wc, wd, wa, aa, f, bb);
    checks++; if (wd !== 16'h1234) begin errors++; $display("FAIL rm_setup: got %h expected 1234", wd); end
    ev = 0;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; byt = 1'b1; addr = 16'h0020; wdata = 16'h0077;
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    checks++; if ({ack, busy, fault, ram_we} !== 4'b0000) begin errors++;
      $display("FAIL rm_ctrl: ack/busy/fault/we=%b expected 0000", {ack, busy, fault, ram_we}); end
    checks++; if ({rdata, ram_addr, ram_din} !== 48'h0) begin errors++;
      $display("FAIL rm_regs: rdata %h addr %h din %h expected 0", rdata, ram_addr, ram_din); end
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ram_we !== 1'b0 || ack !== 1'b0) ev++;
    end
    checks++; if (ev !== 0) begin errors++; $display("FAIL rm_quiet: %0d we/ack cycles expected 0", ev); end
    do_op(1'b0, 1'b0, 16'h0020, 16'h0000, lat, wc, wd, wa, aa, f, bb);
    checks++; if (rdata !== 16'h1234) begin errors++; $display("FAIL rm_mem: got %h expected 1234", rdata); end
  endtask

  task automatic test_misaligned();
    int lat, wc, bb; logic [15:0] wd, wa, aa; logic f;
    do_op(1'b0, 1'b0, 16'h0011, 16'h0000, lat, wc, wd, wa, aa, f, bb);
    checks++; if (wc !== 0) begin errors++; $display("FAIL ma_we: got %0d expected 0", wc); end
`ifdef MEMCTRL_ALIGN_CHECK_EN
    checks++; if (lat !== 1) begin errors++; $display("FAIL ma_lat: got %0d expected 1", lat); end
    checks++; if (f !== 1'b1) begin errors++; $display("FAIL ma_fault: got %b expected 1", f); end
    checks++; if (rdata !== 16'h1234) begin errors++; $display("FAIL ma_rdata: got %h expected 1234", rdata); end
`else
    checks++; if (lat !== 2 + RD_LAT) begin errors++; $display("FAIL ma_lat: got %0d expected %0d", lat, 2 + RD_LAT); end
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL ma_fault: got %b expected 0", f); end
    checks++; if (aa !== 16'h0008) begin errors++; $display("FAIL ma_addr: got %h expected 0008", aa); end
    checks++; if (rdata !== 16'hBE42) begin errors++; $display("FAIL ma_rdata: got %h expected be42", rdata); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_word_store();
    test_word_load();
    test_byte_store_load();
    test_back_to_back();
    test_reset_mid_op();
    test_misaligned();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
